// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared encodings for the exception/CP0 access sequencer
package exc_pkg;

    localparam int NUM_REQ = 6;

    // A request's bit index in the pending vector is also its priority rank: higher index wins.
    localparam int IDX_TEQ     = 0;
    localparam int IDX_BREAK   = 1;
    localparam int IDX_SYSCALL = 2;
    localparam int IDX_MFC0    = 3;
    localparam int IDX_MTC0    = 4;
    localparam int IDX_ERET    = 5;

    localparam logic [NUM_REQ-1:0] EXC_KINDS      = 6'b000111;
    localparam logic [NUM_REQ-1:0] REDIRECT_KINDS = 6'b100111;

    localparam logic [4:0] CAUSE_NONE    = 5'b00000;
    localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
    localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
    localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

    localparam int SR_IE         = 0;
    localparam int SR_SYSCALL_EN = 1;
    localparam int SR_BREAK_EN   = 2;
    localparam int SR_TEQ_EN     = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARB      = 3'd1,
        STROBE   = 3'd2,
        WAIT     = 3'd3,
        REDIRECT = 3'd4
    } state_t;

    function automatic logic [4:0] cause_of(input logic [NUM_REQ-1:0] kind);
        if (kind[IDX_SYSCALL]) return CAUSE_SYSCALL;
        if (kind[IDX_BREAK])   return CAUSE_BREAK;
        if (kind[IDX_TEQ])     return CAUSE_TEQ;
        return CAUSE_NONE;
    endfunction

    function automatic logic exc_masked(input logic [NUM_REQ-1:0] kind, input logic [31:0] status);
        if (kind[IDX_SYSCALL]) return !status[SR_IE] || !status[SR_SYSCALL_EN];
        if (kind[IDX_BREAK])   return !status[SR_IE] || !status[SR_BREAK_EN];
        if (kind[IDX_TEQ])     return !status[SR_IE] || !status[SR_TEQ_EN];
        return 1'b0;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fixed-priority one-hot grant over the pending request vector
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] grant
);

    // Ascending scan so the highest-ranked pending bit is the last write.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pending[i]) begin
                grant = NUM_REQ'(1) << i;
            end
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// rtl/exc_sequencer.sv - serialises decode exception/CP0 requests into CP0 strobes and PC redirects
// Optional build macro EXC_MASK_CHECK_EN: masked exceptions bypass CP0 and resume at pc+4.
module exc_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_syscall,
    input  logic        req_break,
    input  logic        req_teq,
    input  logic        req_eret,
    input  logic        req_mtc0,
    input  logic        req_mfc0,
    input  logic [31:0] req_pc,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_exc_addr,
    output logic        cp0_ena,
    output logic        cp0_exception,
    output logic        cp0_eret,
    output logic        cp0_mtc0,
    output logic        cp0_mfc0,
    output logic [4:0]  cp0_cause,
    output logic [31:0] cp0_pc,
    output logic [4:0]  cp0_addr,
    output logic [31:0] cp0_wdata,
    output logic        pc_we,
    output logic [31:0] pc_next,
    output logic        rf_we,
    output logic        stall
);
    import exc_pkg::*;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] req_vec, pending, pending_set, pending_clr;
    logic [NUM_REQ-1:0] grant, served, kind;

    logic [31:0] slot_pc    [NUM_REQ];
    logic [4:0]  slot_addr  [NUM_REQ];
    logic [31:0] slot_wdata [NUM_REQ];

    logic [31:0] sel_pc, sel_wdata, srv_pc, srv_wdata, cur_pc, cur_wdata;
    logic [4:0]  sel_addr, srv_addr, cur_addr;
    logic        arb_masked, srv_masked, active;

    always_comb begin
        req_vec = '0;
        req_vec[IDX_ERET]    = req_eret;
        req_vec[IDX_MTC0]    = req_mtc0;
        req_vec[IDX_MFC0]    = req_mfc0;
        req_vec[IDX_SYSCALL] = req_syscall;
        req_vec[IDX_BREAK]   = req_break;
        req_vec[IDX_TEQ]     = req_teq;
    end

    assign pending_set = pending | req_vec;

    exc_prio_enc u_prio (
        .pending (pending),
        .grant   (grant)
    );

    always_comb begin
        sel_pc    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_pc    = sel_pc | slot_pc[i];
                sel_addr  = sel_addr | slot_addr[i];
                sel_wdata = sel_wdata | slot_wdata[i];
            end
        end
    end

`ifdef EXC_MASK_CHECK_EN
    always_comb begin
        arb_masked = exc_masked(grant, cp0_status);
    end
`else
    logic status_unused;
    assign status_unused = ^cp0_status;
    always_comb begin
        arb_masked = 1'b0;
    end
`endif

    // A repeated request of the same kind simply overwrites its slot: one service, newest operands.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_vec[i]) begin
                slot_pc[i]    <= req_pc;
                slot_addr[i]  <= req_addr;
                slot_wdata[i] <= req_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            served     <= '0;
            srv_pc     <= '0;
            srv_addr   <= '0;
            srv_wdata  <= '0;
            srv_masked <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= (pending & ~pending_clr) | req_vec;
            if (state == ARB) begin
                served     <= grant;
                srv_pc     <= sel_pc;
                srv_addr   <= sel_addr;
                srv_wdata  <= sel_wdata;
                srv_masked <= arb_masked;
            end
        end
    end

    // During ARB the winner is still only a grant; afterwards it lives in the served registers.
    assign kind      = (state == ARB) ? grant     : served;
    assign cur_pc    = (state == ARB) ? sel_pc    : srv_pc;
    assign cur_addr  = (state == ARB) ? sel_addr  : srv_addr;
    assign cur_wdata = (state == ARB) ? sel_wdata : srv_wdata;
    assign active    = (state == ARB) || (state == STROBE) || (state == WAIT);

    always_comb begin
        state_nxt     = state;
        pending_clr   = '0;
        cp0_ena       = 1'b0;
        cp0_exception = 1'b0;
        cp0_eret      = 1'b0;
        cp0_mtc0      = 1'b0;
        cp0_mfc0      = 1'b0;
        cp0_cause     = CAUSE_NONE;
        cp0_pc        = '0;
        cp0_addr      = '0;
        cp0_wdata     = '0;
        pc_we         = 1'b0;
        pc_next       = '0;
        rf_we         = 1'b0;

        if (active) begin
            cp0_exception = |(kind & EXC_KINDS);
            cp0_eret      = kind[IDX_ERET];
            cp0_mtc0      = kind[IDX_MTC0];
            cp0_mfc0      = kind[IDX_MFC0];
            cp0_cause     = cause_of(kind);
            cp0_pc        = cur_pc;
            cp0_addr      = cur_addr;
            cp0_wdata     = cur_wdata;
        end

        case (state)
            IDLE: begin
                if (pending_set != '0) state_nxt = ARB;
            end
            ARB: begin
                pending_clr = grant;
                if (grant == '0)     state_nxt = IDLE;
                else if (arb_masked) state_nxt = REDIRECT;
                else                 state_nxt = STROBE;
            end
            STROBE: begin
                cp0_ena   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                rf_we     = served[IDX_MFC0];
                state_nxt = REDIRECT;
            end
            REDIRECT: begin
                state_nxt = (pending_set != '0) ? ARB : IDLE;
                if (srv_masked) begin
                    pc_we   = 1'b1;
                    pc_next = srv_pc + 32'd4;
                end else if (|(served & REDIRECT_KINDS)) begin
                    pc_we   = 1'b1;
                    pc_next = cp0_exc_addr;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_exc_sequencer.sv
// tb/tb_exc_sequencer.sv - directed and randomized checks of exc_sequencer against a transaction-level model
module tb_exc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_syscall, req_break, req_teq, req_eret, req_mtc0, req_mfc0;
    logic [31:0] req_pc, req_wdata, cp0_status, cp0_exc_addr;
    logic [4:0]  req_addr;
    logic        cp0_ena, cp0_exception, cp0_eret, cp0_mtc0, cp0_mfc0;
    logic [4:0]  cp0_cause, cp0_addr;
    logic [31:0] cp0_pc, cp0_wdata, pc_next;
    logic        pc_we, rf_we, stall;

    always #5 clk = ~clk;

    exc_sequencer dut (
        .clk(clk), .rst(rst),
        .req_syscall(req_syscall), .req_break(req_break), .req_teq(req_teq),
        .req_eret(req_eret), .req_mtc0(req_mtc0), .req_mfc0(req_mfc0),
        .req_pc(req_pc), .req_addr(req_addr), .req_wdata(req_wdata),
        .cp0_status(cp0_status), .cp0_exc_addr(cp0_exc_addr),
        .cp0_ena(cp0_ena), .cp0_exception(cp0_exception), .cp0_eret(cp0_eret),
        .cp0_mtc0(cp0_mtc0), .cp0_mfc0(cp0_mfc0), .cp0_cause(cp0_cause),
        .cp0_pc(cp0_pc), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .pc_we(pc_we), .pc_next(pc_next), .rf_we(rf_we), .stall(stall)
    );

    int checks = 0;
    int errors = 0;

    // Bench kind numbering: list order is service priority (0 = most urgent).
    localparam int K_ERET = 0, K_MTC0 = 1, K_MFC0 = 2, K_SYS = 3, K_BRK = 4, K_TEQ = 5;

    bit          mp  [6];
    logic [31:0] mpc [6];
    logic [31:0] mwd [6];
    logic [4:0]  mad [6];
    int          phase = -1;   // -1 idle, 0..3 = cycle within one 4-cycle service
    int          cur = 0;
    logic [31:0] cpc, cwd;
    logic [4:0]  cad;
    bit          cmask;

    int          n_pcwe, n_rfwe, n_ena, n_stall_lo;
    logic [31:0] last_pc_next, mtc0_wdata;
    logic [4:0]  mtc0_addr;
    int          ena_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < 6; k++) if (mp[k]) return k;
        return -1;
    endfunction

    function automatic bit is_exc(input int k);
        return (k == K_SYS) || (k == K_BRK) || (k == K_TEQ);
    endfunction

    function automatic bit masked(input int k, input logic [31:0] st);
`ifdef EXC_MASK_CHECK_EN
        int b;
        if (!is_exc(k)) return 1'b0;
        b = (k == K_SYS) ? 1 : (k == K_BRK) ? 2 : 3;
        return (st[0] == 1'b0) || (st[b] == 1'b0);
`else
        return (k < 0) && (st == 32'h0);
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) mp[k] = 1'b0;
        phase = -1;
        cur   = 0;
        cmask = 1'b0;
    endtask

    task automatic model_step(input logic [5:0] rv, input logic r);
        int nphase;
        bit any;
        if (r) begin
            model_reset();
            return;
        end
        nphase = phase;
        if (phase == 0) begin
            cur       = pick();
            mp[cur]   = 1'b0;
            cpc       = mpc[cur];
            cad       = mad[cur];
            cwd       = mwd[cur];
            cmask     = masked(cur, cp0_status);
            nphase    = cmask ? 3 : 1;
        end else if (phase == 1) nphase = 2;
        else if (phase == 2) nphase = 3;
        for (int k = 0; k < 6; k++) begin
            if (rv[k]) begin
                mp[k]  = 1'b1;
                mpc[k] = req_pc;
                mad[k] = req_addr;
                mwd[k] = req_wdata;
            end
        end
        any = (pick() >= 0);
        if (phase == -1 || phase == 3) nphase = any ? 0 : -1;
        phase = nphase;
    endtask

    task automatic check_outputs();
        int k;
        bit act, eexc, epcwe, eena, erfwe, estall;
        logic [31:0] epc, ewd, enext;
        logic [4:0]  ead, ecause;
        k   = (phase == 0) ? pick() : cur;
        act = (phase >= 0) && (phase <= 2) && (k >= 0);
        epc = '0; ewd = '0; ead = '0; ecause = '0; eexc = 1'b0;
        if (act) begin
            if (phase == 0) begin epc = mpc[k]; ead = mad[k]; ewd = mwd[k]; end
            else            begin epc = cpc;    ead = cad;    ewd = cwd;    end
            eexc   = is_exc(k);
            ecause = (k == K_SYS) ? 5'b01000 : (k == K_BRK) ? 5'b01001 : (k == K_TEQ) ? 5'b01101 : 5'b0;
        end
        eena   = (phase == 1);
        erfwe  = (phase == 2) && (cur == K_MFC0);
        epcwe  = (phase == 3) && (cmask || (cur != K_MTC0 && cur != K_MFC0));
        enext  = !epcwe ? 32'h0 : cmask ? cpc + 32'd4 : cp0_exc_addr;
        estall = (phase != -1) || (pick() >= 0);
        chk("cp0_ena",       32'(cp0_ena),       32'(eena));
        chk("cp0_exception", 32'(cp0_exception), 32'(eexc));
        chk("cp0_eret",      32'(cp0_eret),      32'(act && k == K_ERET));
        chk("cp0_mtc0",      32'(cp0_mtc0),      32'(act && k == K_MTC0));
        chk("cp0_mfc0",      32'(cp0_mfc0),      32'(act && k == K_MFC0));
        chk("cp0_cause",     32'(cp0_cause),     32'(ecause));
        chk("cp0_pc",        cp0_pc,             epc);
        chk("cp0_addr",      32'(cp0_addr),      32'(ead));
        chk("cp0_wdata",     cp0_wdata,          ewd);
        chk("pc_we",         32'(pc_we),         32'(epcwe));
        chk("pc_next",       pc_next,            enext);
        chk("rf_we",         32'(rf_we),         32'(erfwe));
        chk("stall",         32'(stall),         32'(estall));
    endtask

    task automatic capture();
        if (pc_we) begin n_pcwe++; last_pc_next = pc_next; end
        if (rf_we) n_rfwe++;
        if (!stall) n_stall_lo++;
        if (cp0_ena) begin
            n_ena++;
            ena_log.push_back(cp0_eret ? 100 : cp0_mtc0 ? 101 : cp0_mfc0 ? 102 : int'(cp0_cause));
            if (cp0_mtc0) begin mtc0_addr = cp0_addr; mtc0_wdata = cp0_wdata; end
        end
    endtask

    task automatic clear_counts();
        n_pcwe = 0; n_rfwe = 0; n_ena = 0; n_stall_lo = 0;
        last_pc_next = '0;
        ena_log.delete();
    endtask

    task automatic cycle(input logic [5:0] rv, input logic [31:0] pc, input logic [4:0] addr,
                         input logic [31:0] wd, input logic r);
        @(negedge clk);
        rst = r;
        req_eret = rv[K_ERET]; req_mtc0 = rv[K_MTC0]; req_mfc0 = rv[K_MFC0];
        req_syscall = rv[K_SYS]; req_break = rv[K_BRK]; req_teq = rv[K_TEQ];
        req_pc = pc; req_addr = addr; req_wdata = wd;
        #1;
        check_outputs();
        capture();
        @(posedge clk);
        model_step(rv, r);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(6'b0, 32'h0, 5'h0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [5:0] rv;
        rst = 1'b1;
        req_syscall = 0; req_break = 0; req_teq = 0; req_eret = 0; req_mtc0 = 0; req_mfc0 = 0;
        req_pc = '0; req_addr = '0; req_wdata = '0;
        cp0_status = 32'h1f; cp0_exc_addr = 32'h0040_0004;
        repeat (2) @(posedge clk);
        model_reset();
        clear_counts();
        idle(2);

        // Single syscall from idle
        cycle(6'b1 << K_SYS, 32'h0040_0100, 5'h0, 32'h0, 1'b0);
        clear_counts();
        idle(1);
        cycle(6'b0, 32'h0, 5'h0, 32'h0, 1'b0);
        chk("req027_ena_cycle2", 32'(cp0_ena), 32'h1);
        chk("req027_cause", 32'(cp0_cause), 32'h08);
        idle(1);
        cycle(6'b0, 32'h0, 5'h0, 32'h0, 1'b0);
        chk("req027_pcwe_cycle4", 32'(pc_we), 32'h1);
        chk("req027_pc_next", pc_next, 32'h0040_0004);
        idle(2);

        // Three simultaneous requests
        cycle((6'b1 << K_SYS) | (6'b1 << K_BRK) | (6'b1 << K_ERET), 32'h0000_2000, 5'h0, 32'h0, 1'b0);
        clear_counts();
        idle(12);
        chk("req028_pcwe_count", n_pcwe, 3);
        chk("req028_stall_low", n_stall_lo, 0);
        chk("req028_ena_count", ena_log.size(), 3);
        if (ena_log.size() == 3) begin
            chk("req028_order0", ena_log[0], 100);
            chk("req028_order1", ena_log[1], 8);
            chk("req028_order2", ena_log[2], 9);
        end
        idle(2);

        // mtc0 then mfc0
        clear_counts();
        cycle(6'b1 << K_MTC0, 32'h0000_3000, 5'd12, 32'h3, 1'b0);
        cycle(6'b1 << K_MFC0, 32'h0000_3004, 5'd12, 32'h0, 1'b0);
        idle(9);
        chk("req029_mtc0_addr", 32'(mtc0_addr), 32'd12);
        chk("req029_mtc0_wdata", mtc0_wdata, 32'h3);
        chk("req029_rfwe_count", n_rfwe, 1);
        chk("req029_no_pcwe", n_pcwe, 0);

        // teq under enabled and disabled status
        cp0_status = 32'h1d;
        clear_counts();
        cycle(6'b1 << K_TEQ, 32'h0000_0100, 5'h0, 32'h0, 1'b0);
        idle(6);
        chk("req030_en_ena", n_ena, 1);
        chk("req030_en_pc_next", last_pc_next, 32'h0040_0004);
        cp0_status = 32'h15;
        clear_counts();
        cycle(6'b1 << K_TEQ, 32'h0000_0100, 5'h0, 32'h0, 1'b0);
        idle(6);
`ifdef EXC_MASK_CHECK_EN
        chk("req030_masked_no_ena", n_ena, 0);
        chk("req030_masked_pc_next", last_pc_next, 32'h0000_0104);
`else
        chk("req024_unmasked_ena", n_ena, 1);
        chk("req024_unmasked_pc_next", last_pc_next, 32'h0040_0004);
`endif
        chk("req030_pcwe_count", n_pcwe, 1);
        cp0_status = 32'h1f;

        // Reset while in STROBE with two pending
        cycle((6'b1 << K_SYS) | (6'b1 << K_BRK), 32'h0000_4000, 5'h0, 32'h0, 1'b0);
        idle(1);
        cycle(6'b0, 32'h0, 5'h0, 32'h0, 1'b1);
        chk("req031_in_strobe", 32'(cp0_ena), 32'h1);
        clear_counts();
        idle(1);
        chk("req031_stall", 32'(stall), 32'h0);
        chk("req031_exception", 32'(cp0_exception), 32'h0);
        idle(6);
        chk("req031_no_pcwe", n_pcwe, 0);
        chk("req031_no_ena", n_ena, 0);

        // Randomized traffic
        for (int t = 0; t < 600; t++) begin
            rv = '0;
            for (int k = 0; k < 6; k++) rv[k] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 4))
                    0: cp0_status = 32'h1f;
                    1: cp0_status = 32'h1d;
                    2: cp0_status = 32'h15;
                    3: cp0_status = 32'h1e;
                    default: cp0_status = $urandom;
                endcase
            end
            if ($urandom_range(0, 19) == 0) cp0_exc_addr = $urandom;
            cycle(rv, $urandom, 5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 149) == 0));
        end
        idle(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exc_sequencer.md
EXC_SEQUENCER -- requirements
Module: exc_sequencer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have ports req_syscall, req_break, req_teq, req_eret  input  1 each  one-cycle request pulses from decode.
REQ-004 SHALL have ports req_mtc0, req_mfc0  input  1 each  one-cycle CP0 register access pulses.
REQ-005 SHALL have ports req_pc  input  32  PC of the requesting instruction; req_addr  input  5  CP0 register number; req_wdata  input  32  mtc0 data.
REQ-006 SHALL have ports cp0_status  input  32  CP0 status; cp0_exc_addr  input  32  CP0 redirect target.
REQ-007 SHALL have ports cp0_ena, cp0_exception, cp0_eret, cp0_mtc0, cp0_mfc0  output  1 each  CP0 control.
REQ-008 SHALL have ports cp0_cause  output  5; cp0_pc  output  32; cp0_addr  output  5; cp0_wdata  output  32.
REQ-009 SHALL have ports pc_we  output  1  PC load pulse; pc_next  output  32  PC load value; rf_we  output  1  mfc0 result write pulse; stall  output  1  core freeze.

Function
REQ-010 SHALL set the bit of each asserted request in a 6-bit pending register on every edge, including while busy; simultaneous requests are all retained.
REQ-011 SHALL latch req_pc, req_addr, req_wdata into the pending slot of each request accepted in that cycle.
REQ-012 SHALL implement states IDLE, ARB, STROBE, WAIT, REDIRECT.
REQ-013 SHALL move IDLE->ARB when any pending bit is set, else stay in IDLE.
REQ-014 SHALL in ARB select one pending request with fixed priority eret > mtc0 > mfc0 > syscall > break > teq, and clear its pending bit.
REQ-015 SHALL drive the selected control line, cp0_cause (syscall 5'b01000, break 5'b01001, teq 5'b01101, else 0), cp0_pc, cp0_addr, cp0_wdata from ARB through WAIT inclusive.
REQ-016 SHALL drive cp0_ena high for exactly the STROBE cycle and low otherwise.
REQ-017 SHALL in WAIT pulse rf_we for one cycle when the served request is mfc0.
REQ-018 SHALL in REDIRECT pulse pc_we with pc_next = cp0_exc_addr for eret/syscall/break/teq; for mtc0/mfc0, pc_we stays 0.
REQ-019 SHALL transition REDIRECT->ARB if pending is nonzero, else ->IDLE.
REQ-020 SHALL hold stall high whenever state != IDLE or pending != 0; latency from request pulse to pc_we is 4 cycles when idle.
REQ-021 SHALL treat a request that repeats a kind already pending as merged: one service, last-latched operands win.

Reset
REQ-022 SHALL on rst (synchronous) enter IDLE, clear pending, and drive every output to 0 by the next edge, including mid-operation.

Configuration
REQ-023 SHALL implement macro EXC_MASK_CHECK_EN: when defined, in ARB an exception with cp0_status[0]=0 or its enable bit clear (syscall bit1, break bit2, teq bit3) SHALL skip STROBE/WAIT, go to REDIRECT, and load pc_next = cp0_pc + 4 with cp0_ena never asserted.
REQ-024 SHALL, when EXC_MASK_CHECK_EN is undefined, issue every exception to CP0 unconditionally and take pc_next from cp0_exc_addr.

Structure
REQ-025 SHALL place state encoding, cause codes, status bit indices and priority order in shared package exc_pkg.
REQ-026 SHALL implement the priority selection as sub-module exc_prio_enc (6-bit pending in, one-hot grant out).

Verification
REQ-027 Single syscall, pc=0x00400100, status=0x1f, cp0_exc_addr=0x00400004 -> cp0_ena on cycle 2, cp0_cause=5'b01000, pc_we on cycle 4 with pc_next=0x00400004.
REQ-028 Syscall, break, eret pulsed same cycle -> served eret, syscall, break in that order; three pc_we pulses, stall high throughout.
REQ-029 mtc0 addr=12 wdata=0x3 then mfc0 addr=12 -> cp0_mtc0 with cp0_addr=12/cp0_wdata=0x3, then rf_we pulse in WAIT; no pc_we.
REQ-030 EXC_MASK_CHECK_EN defined, status=0x1d, teq pc=0x100 -> served normally; status=0x15, teq pc=0x100 -> no cp0_ena, pc_next=0x104.
REQ-031 rst asserted in STROBE with two requests pending -> next cycle IDLE, pending=0, all outputs 0, no pc_we.
